// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state type, instruction field positions and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StHold
  } fetch_state_e;

  localparam int unsigned OpcodeLsb = 6;
  localparam int unsigned RsLsb     = 4;
  localparam int unsigned RtLsb     = 2;
  localparam int unsigned RdLsb     = 0;

  localparam int unsigned DefaultResetPc = 0;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Master is the fetch side; slave is the memory side.
interface fetch_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 8
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry skid register holding an instruction fetched while IF/ID was stalled.
// Clear takes priority over load.
module fetch_skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o
);

  logic [Width-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem requests, owns the PC and the IF/ID register,
// and parks an instruction in a skid buffer when the pipeline stalls mid-fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 8,
  parameter int unsigned         INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DefaultResetPc)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_taken_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  fetch_if.master                imem,
  output logic [INSTR_WIDTH-1:0] if_id_instr_o,
  output logic [PC_WIDTH-1:0]    if_id_pc_o,
  output logic                   if_id_valid_o,
  output logic [1:0]             id_rs_o,
  output logic [1:0]             id_rt_o
);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    ifpc_q, ifpc_d;
  logic                   valid_q, valid_d;
  logic                   skid_load, skid_clear, skid_full;
  logic [INSTR_WIDTH-1:0] skid_data;
  logic                   req;

  fetch_skid_buf #(
    .Width (INSTR_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (imem.imem_rdata),
    .data_o  (skid_data),
    .full_o  (skid_full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    req        = 1'b0;
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        req = 1'b1;
        if (branch_taken_i) begin
          // Redirect wins; the response arriving this cycle belongs to the wrong path.
          pc_d       = branch_target_i;
          valid_d    = 1'b0;
          skid_clear = 1'b1;
        end else if (imem.imem_ready && !stall_i) begin
          instr_d = imem.imem_rdata;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(1);
        end else if (imem.imem_ready) begin
          skid_load = 1'b1;
          state_d   = StHold;
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (branch_taken_i) begin
          pc_d       = branch_target_i;
          valid_d    = 1'b0;
          skid_clear = 1'b1;
          state_d    = StFetch;
        end else if (!stall_i) begin
          instr_d    = skid_data;
          ifpc_d     = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_WIDTH'(1);
          skid_clear = 1'b1;
          state_d    = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign if_id_instr_o  = instr_q;
  assign if_id_pc_o     = ifpc_q;
  assign if_id_valid_o  = valid_q;
  assign id_rs_o        = valid_q ? instr_q[RsLsb +: 2] : 2'b00;
  assign id_rt_o        = valid_q ? instr_q[RtLsb +: 2] : 2'b00;

endmodule
